// File: rtl/manycore_pkg.sv
// Shared manycore types: arbiter state encoding and requester indices.
package manycore_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_SWITCH
  } e_arb_state;

  localparam int REQ_CPU    = 0;
  localparam int REQ_DMA_RX = 1;
  localparam int REQ_DMA_TX = 2;

endpackage

// File: rtl/pe_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping.
// Shared with the router output arbiters.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int p;

  // NOTE: every output gets a default before the search so no path leaves a latch behind.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int off = 1; off <= N; off++) begin
      p = (int'(ptr) + off) % N;
      if (!valid && req[p[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = p[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Time-sliced round-robin arbiter for the PE single-port RAM bus (CPU, DMA-RX, DMA-TX).
// Define PE_MEM_ARB_STATS_EN to add per-requester grant and max-wait statistics.
module pe_mem_arbiter
  import manycore_pkg::*;
#(
  parameter int N_REQ              = 3,
  parameter int INTERLEAVING_GRAIN = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] lock_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [1:0]       grant_idx_o,
  output logic             busy_o,
  output logic             switch_o
`ifdef PE_MEM_ARB_STATS_EN
  ,
  input  logic             stat_clr_i,
  output logic [31:0]      stat_grants_o  [N_REQ],
  output logic [15:0]      stat_maxwait_o [N_REQ]
`endif
);

  localparam int CNT_W = $clog2(INTERLEAVING_GRAIN + 1);
  localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(INTERLEAVING_GRAIN - 1);

  e_arb_state       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] slice_q, slice_d;
  logic             switch_q, switch_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [N_REQ-1:0] others;
  logic             owner_req, owner_lock, go_switch;

  rr_pick #(.N(N_REQ), .IDX_W(2)) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign others     = req_i & ~grant_q;
  assign owner_req  = |(req_i & grant_q);
  assign owner_lock = |(lock_i & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    slice_d   = slice_q;
    switch_d  = 1'b0;
    go_switch = 1'b0;
    unique case (state_q)
      ARB_IDLE, ARB_SWITCH: begin
        grant_d = '0;
        state_d = ARB_IDLE;
        if (pick_valid) begin
          state_d = ARB_GRANT;
          grant_d = N_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          slice_d = '0;
        end
      end
      ARB_GRANT: begin
        // Release takes priority over grain expiry, so the two can never stack.
        if (!owner_req) begin
          grant_d   = '0;
          slice_d   = '0;
          state_d   = ARB_IDLE;
          go_switch = |others;
        end else if (slice_q == SLICE_LAST) begin
          if (!(|others)) slice_d = '0;
          else go_switch = !owner_lock;
        end else begin
          slice_d = slice_q + 1'b1;
        end
        if (go_switch) begin
          grant_d  = '0;
          slice_d  = '0;
          state_d  = ARB_SWITCH;
          switch_d = 1'b1;
          rr_ptr_d = idx_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= 2'(N_REQ - 1);
      slice_q  <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      slice_q  <= slice_d;
      switch_q <= switch_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = |grant_q;
  assign switch_o    = switch_q;

`ifdef PE_MEM_ARB_STATS_EN
  for (genvar k = 0; k < N_REQ; k++) begin : g_stat
    logic [31:0] grants_q, grants_d;
    logic [15:0] maxwait_q, maxwait_d;
    logic [15:0] wait_q, wait_d;
    logic        new_grant;

    // Wait counts cycles spent requesting without the bus, sampled at the grant edge.
    assign new_grant = (state_q != ARB_GRANT) && (state_d == ARB_GRANT) && grant_d[k];

    always_comb begin
      grants_d  = grants_q;
      maxwait_d = maxwait_q;
      wait_d    = '0;
      if (new_grant) begin
        grants_d = grants_q + 1'b1;
        if (wait_q > maxwait_q) maxwait_d = wait_q;
      end else if (req_i[k] && !grant_q[k]) begin
        wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 1'b1;
      end
      if (stat_clr_i) begin
        grants_d  = '0;
        maxwait_d = '0;
        wait_d    = '0;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        grants_q  <= '0;
        maxwait_q <= '0;
        wait_q    <= '0;
      end else begin
        grants_q  <= grants_d;
        maxwait_q <= maxwait_d;
        wait_q    <= wait_d;
      end
    end

    assign stat_grants_o[k]  = grants_q;
    assign stat_maxwait_o[k] = maxwait_q;
  end
`endif

  a_grant_onehot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_o));
  a_grant_had_req: assert property (@(posedge clock) disable iff (reset)
    (grant_o & ~$past(req_i)) == '0);
  a_switch_not_busy: assert property (@(posedge clock) disable iff (reset)
    !(switch_o && busy_o));

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Self-checking bench for pe_mem_arbiter: directed scenarios plus random traffic against
// a cycle-level ownership model; statistics checks need PE_MEM_ARB_STATS_EN.
module tb_pe_mem_arbiter;

  localparam int N     = 3;
  localparam int GRAIN = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req_i  = '0;
  logic [N-1:0] lock_i = '0;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_idx_o;
  logic         busy_o;
  logic         switch_o;
`ifdef PE_MEM_ARB_STATS_EN
  logic         stat_clr_i = 1'b0;
  logic [31:0]  stat_grants_o  [N];
  logic [15:0]  stat_maxwait_o [N];
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pe_mem_arbiter #(.N_REQ(N), .INTERLEAVING_GRAIN(GRAIN)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_i       (req_i),
    .lock_i      (lock_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .busy_o      (busy_o),
    .switch_o    (switch_o)
`ifdef PE_MEM_ARB_STATS_EN
    ,
    .stat_clr_i     (stat_clr_i),
    .stat_grants_o  (stat_grants_o),
    .stat_maxwait_o (stat_maxwait_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership model: who holds the bus, for how long, and whether this is a turnaround cycle.
  int  m_owner;
  bit  m_valid;
  bit  m_turn;
  int  m_held;
  int  m_ptr;
  int  m_grants [N];
  int  m_nxt;
  logic [N-1:0] m_rest;

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int rr(input logic [N-1:0] r, input int after);
    for (int o = 1; o <= N; o++)
      if (bit_of(r, (after + o) % N)) return (after + o) % N;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner = 0; m_valid = 0; m_turn = 0; m_held = 0; m_ptr = N - 1;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
    end else if (!m_valid) begin
      m_turn = 0;
      m_nxt  = rr(req_i, m_ptr);
      if (m_nxt >= 0) begin
        m_owner = m_nxt; m_valid = 1; m_held = 1; m_grants[m_nxt]++;
      end
    end else begin
      m_rest = req_i & ~(N'(1) << m_owner);
      if (!bit_of(req_i, m_owner)) begin
        m_valid = 0;
        if (m_rest != 0) begin m_turn = 1; m_ptr = m_owner; end
      end else if (m_held >= GRAIN) begin
        if (m_rest == 0) m_held = 1;
        else if (!bit_of(lock_i, m_owner)) begin
          m_valid = 0; m_turn = 1; m_ptr = m_owner;
        end
      end else begin
        m_held++;
      end
    end
  end

  logic [N-1:0] exp_grant;
  always @(negedge clock) begin
    exp_grant = m_valid ? (N'(1) << m_owner) : '0;
    check("grant", grant_o, exp_grant);
    check("grant_idx", grant_idx_o, 32'(m_owner));
    check("busy", busy_o, m_valid);
    check("switch", switch_o, m_turn);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int nsw;
  logic [N-1:0] s2_exp;

  initial begin
    #1 reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Reset in the middle of owner 1's slice 5.
    req_i = 3'b010;
    repeat (6) step();
    check("s1_pre_grant", grant_o, 3'b010);
    reset = 1'b1;
    #1;
    check("s1_rst_grant", grant_o, 3'b000);
    check("s1_rst_idx", grant_idx_o, 2'd0);
    check("s1_rst_busy", busy_o, 1'b0);
    check("s1_rst_switch", switch_o, 1'b0);
    step();
    reset = 1'b0;
    req_i = 3'b011;
    step();
    check("s1_first_grant", grant_o, 3'b001);
    req_i = 3'b000;
    repeat (3) step();
    check("s1_idle_busy", busy_o, 1'b0);

    // All three requesting: 10-cycle slices, one turnaround cycle each, period 33.
    req_i = 3'b111;
    nsw = 0;
    for (int k = 1; k <= 34; k++) begin
      step();
      nsw += int'(switch_o);
      if (k <= 10)      s2_exp = 3'b001;
      else if (k == 11) s2_exp = 3'b000;
      else if (k <= 21) s2_exp = 3'b010;
      else if (k == 22) s2_exp = 3'b000;
      else if (k <= 32) s2_exp = 3'b100;
      else if (k == 33) s2_exp = 3'b000;
      else              s2_exp = 3'b001;
      check("s2_rotate", grant_o, s2_exp);
    end
    check("s2_switch_count", nsw, 3);
`ifdef PE_MEM_ARB_STATS_EN
    check("s2_maxwait2", stat_maxwait_o[2], 16'd22);
`endif

    // Sole requester: never preempted.
    req_i = 3'b100;
    repeat (2) step();
    check("s3_enter", grant_o, 3'b100);
    nsw = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      nsw += int'(switch_o);
    end
    check("s3_hold", grant_o, 3'b100);
    check("s3_no_switch", nsw, 0);

    // Owner 0 locked past its grain with requester 1 waiting.
    req_i = 3'b001;
    repeat (2) step();
    check("s4_enter", grant_o, 3'b001);
    req_i  = 3'b011;
    lock_i = 3'b001;
    repeat (20) step();
    check("s4_locked", grant_o, 3'b001);
    lock_i = 3'b000;
    step();
    check("s4_switch", switch_o, 1'b1);
    step();
    check("s4_new_owner", grant_o, 3'b010);

    // Owner 1 drops at slice 3 with requester 0 pending, then nobody pending.
    repeat (3) step();
    req_i = 3'b001;
    step();
    check("s5_switch", switch_o, 1'b1);
    check("s5_switch_grant", grant_o, 3'b000);
    step();
    check("s5_owner0", grant_o, 3'b001);
    req_i = 3'b000;
    step();
    check("s5_idle_grant", grant_o, 3'b000);
    check("s5_idle_switch", switch_o, 1'b0);

    // Release in the same cycle the grain expires: exactly one turnaround.
    req_i = 3'b011;
    step();
    check("s6_enter", grant_o, 3'b001);
    repeat (9) step();
    req_i = 3'b010;
    step();
    check("s6_switch", switch_o, 1'b1);
    step();
    check("s6_no_second_switch", switch_o, 1'b0);
    check("s6_owner1", grant_o, 3'b010);

    // Random traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)  req_i  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) lock_i = 3'($urandom_range(0, 7));
      step();
    end
    lock_i = 3'b000;

`ifdef PE_MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_grants", stat_grants_o[i], 32'(m_grants[i]));
    req_i = 3'b000;
    repeat (3) step();
    stat_clr_i = 1'b1;
    step();
    stat_clr_i = 1'b0;
    check("stat_clr_grants0", stat_grants_o[0], 32'd0);
    check("stat_clr_maxwait2", stat_maxwait_o[2], 16'd0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
